// File: rtl/coax_pkg.sv
// rtl/coax_pkg.sv - shared states, error codes and timing windows for the coax receiver
package coax_pkg;

    localparam int WORD_W = 10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CV_HIGH = 3'd1;
    localparam state_t ST_CV_LOW  = 3'd2;
    localparam state_t ST_SYNC    = 3'd3;
    localparam state_t ST_DATA    = 3'd4;
    localparam state_t ST_PARITY  = 3'd5;
    localparam state_t ST_END     = 3'd6;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_PARITY   = 2'd1;
    localparam logic [1:0] ERR_MID_BIT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    // Code-violation runs last between 1.25 and 1.75 bit cells.
    function automatic int cv_min(input int cpb);
        return (5 * cpb + 3) / 4;
    endfunction

    function automatic int cv_max(input int cpb);
        return (7 * cpb) / 4;
    endfunction

    // Mid-bit transitions arrive one cell (+/- a quarter cell) after the previous one.
    function automatic int mid_min(input int cpb);
        return cpb - cpb / 4;
    endfunction

    function automatic int mid_max(input int cpb);
        return cpb + cpb / 4;
    endfunction

endpackage

// File: rtl/coax_rx_fifo.sv
// rtl/coax_rx_fifo.sv - first-word-fall-through word buffer for received coax words
module coax_rx_fifo
    import coax_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign do_rd     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    // The head reads as zero while empty so stale storage never leaks out.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Word storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (do_rd && !do_wr) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/coax_buffered_rx.sv
// rtl/coax_buffered_rx.sv - Manchester coax line decoder with buffered 10-bit word output
module coax_buffered_rx
    import coax_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = 8,
    parameter int DEPTH          = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       active,
    output logic       error,
    output logic [1:0] error_code,
    output logic [9:0] data,
    input  logic       read_strobe,
    output logic       empty,
    output logic       full
);
    localparam int CW = $clog2(2 * CLOCKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CV_MIN  = CW'(cv_min(CLOCKS_PER_BIT));
    localparam logic [CW-1:0] CV_MAX  = CW'(cv_max(CLOCKS_PER_BIT));
    localparam logic [CW-1:0] MID_MIN = CW'(mid_min(CLOCKS_PER_BIT));
    localparam logic [CW-1:0] MID_MAX = CW'(mid_max(CLOCKS_PER_BIT));

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]     run_cnt_q, run_cnt_d;
    logic [CW-1:0]     mid_cnt_q, mid_cnt_d;
    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] push_word_q, push_word_d;
    logic              push_q, push_d;
    logic              active_q, active_d;
    logic              error_q, error_d;
    logic [1:0]        code_q, code_d;
    logic [1:0]        fault;
    logic              resync;
    logic              edge_w, run_ok, mid_edge, mid_timeout, overflow;

    assign edge_w      = rx_sync_q ^ rx_prev_q;
    assign run_ok      = (run_cnt_q >= CV_MIN) && (run_cnt_q <= CV_MAX);
    assign mid_edge    = edge_w && (mid_cnt_q >= MID_MIN) && (mid_cnt_q <= MID_MAX);
    assign mid_timeout = !mid_edge && (mid_cnt_q >= MID_MAX);
    assign overflow    = push_q && full && !read_strobe;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Run length counts every edge; mid-bit timer restarts only on mid-bit transitions.
    always_comb begin
        run_cnt_d = edge_w ? CW'(1) : ((run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 1'b1);
        mid_cnt_d = resync ? CW'(1) : ((mid_cnt_q == '1) ? mid_cnt_q : mid_cnt_q + 1'b1);
    end

    // Decoder state machine: start detection, deserialization, parity and end handling.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        active_d    = active_q;
        error_d     = error_q;
        code_d      = code_q;
        resync      = 1'b0;
        fault       = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (edge_w && !rx_sync_q && run_ok) begin
                    state_d = ST_CV_HIGH;
                end
            end
            ST_CV_HIGH: begin
                if (edge_w) begin
                    state_d = (rx_sync_q && run_ok) ? ST_CV_LOW : ST_IDLE;
                end
            end
            ST_CV_LOW: begin
                // The falling cell boundary is skipped; the rise is the sync-bit middle.
                if (edge_w && rx_sync_q) begin
                    resync    = 1'b1;
                    active_d  = 1'b1;
                    error_d   = 1'b0;
                    code_d    = ERR_NONE;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid_edge) begin
                    resync    = 1'b1;
                    shift_d   = {shift_q[WORD_W-2:0], rx_sync_q};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_PARITY;
                    end
                end else if (mid_timeout) begin
                    fault = ERR_MID_BIT;
                end
            end
            ST_PARITY: begin
                if (mid_edge) begin
                    resync = 1'b1;
                    if (^{shift_q, rx_sync_q}) begin
                        fault = ERR_PARITY;
                    end else begin
                        push_d      = 1'b1;
                        push_word_d = shift_q;
                        state_d     = ST_SYNC;
                    end
                end else if (mid_timeout) begin
                    fault = ERR_MID_BIT;
                end
            end
            ST_SYNC: begin
                if (mid_edge) begin
                    resync = 1'b1;
                    if (rx_sync_q) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ST_DATA;
                    end else begin
                        state_d = ST_END;
                    end
                end else if (mid_timeout) begin
                    fault = ERR_MID_BIT;
                end
            end
            ST_END: begin
                if (mid_cnt_q >= MID_MAX) begin
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The push lands one cycle after parity, so overflow is judged then.
        if (overflow) begin
            fault = ERR_OVERFLOW;
        end
        if (fault != ERR_NONE) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            error_d  = 1'b1;
            code_d   = fault;
            push_d   = 1'b0;
        end
    end

    // Decoder state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt_q   <= '0;
            mid_cnt_q   <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            active_q    <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            run_cnt_q   <= run_cnt_d;
            mid_cnt_q   <= mid_cnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            push_word_q <= push_word_d;
            active_q    <= active_d;
            error_q     <= error_d;
            code_q      <= code_d;
        end
    end

    assign active     = active_q;
    assign error      = error_q;
    assign error_code = code_q;

    coax_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_en_i   (push_q),
        .wr_data_i (push_word_q),
        .rd_en_i   (read_strobe),
        .rd_data_o (data),
        .empty_o   (empty),
        .full_o    (full)
    );

endmodule

// File: tb/tb_coax_buffered_rx.sv
// tb/tb_coax_buffered_rx.sv - scoreboard bench for coax_buffered_rx
module tb_coax_buffered_rx;
    localparam int CPB   = 8;
    localparam int DEPTH = 8;
    localparam int HALF  = CPB / 2;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       active;
    logic       error;
    logic [1:0] error_code;
    logic [9:0] data;
    logic       read_strobe;
    logic       empty;
    logic       full;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [9:0] exp_q[$];
    bit         reader_en = 1'b1;
    bit         force_rd  = 1'b0;
    int         exp_error = 0;
    int         exp_code  = 0;

    logic [9:0]  msg_words[16];
    int          msg_n;
    logic [15:0] msg_inv;
    int          msg_sup;
    int          cv_hi;
    int          cv_lo;
    int          reset_at;

    coax_buffered_rx #(.CLOCKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .active      (active),
        .error       (error),
        .error_code  (error_code),
        .data        (data),
        .read_strobe (read_strobe),
        .empty       (empty),
        .full        (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Monitor: pops the head whenever the reader is enabled and compares to the scoreboard.
    initial begin
        read_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (force_rd) begin
                read_strobe = 1'b1;
            end else if (reader_en && !reset && !empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %0h required none", data);
                end else begin
                    check("word", data, exp_q.pop_front());
                end
                read_strobe = 1'b1;
            end else begin
                read_strobe = 1'b0;
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        hold(~b, HALF);
        hold(b, HALF);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_active"}, active, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_code"}, error_code, 0);
        check({tag, "_data"}, data, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
    endtask

    task automatic new_msg(input int n, input int hi, input int lo);
        msg_n    = n;
        cv_hi    = hi;
        cv_lo    = lo;
        msg_inv  = '0;
        msg_sup  = -1;
        reset_at = -1;
        for (int i = 0; i < n; i++) msg_words[i] = 10'($urandom_range(0, 1023));
    endtask

    // Reference: decides from the message description which words must be stored and
    // what fault, if any, the message leaves behind.
    task automatic model_msg(output bit exp_active);
        int ones;
        int par;
        exp_active = (real'(cv_hi) >= 1.25 * CPB) && (real'(cv_hi) <= 1.75 * CPB) &&
                     (real'(cv_lo) >= 1.25 * CPB) && (real'(cv_lo) <= 1.75 * CPB);
        if (!exp_active) return;
        exp_error = 0;
        exp_code  = 0;
        for (int w = 0; w < msg_n; w++) begin
            if (w == msg_sup) begin
                exp_error = 1; exp_code = 2; return;
            end
            ones = $countones(msg_words[w]);
            par  = (ones % 2) ^ int'(msg_inv[w]);
            if ((ones + par) % 2 != 0) begin
                exp_error = 1; exp_code = 1; return;
            end
            if (!reader_en && exp_q.size() == DEPTH) begin
                exp_error = 1; exp_code = 3; return;
            end
            exp_q.push_back(msg_words[w]);
        end
    endtask

    task automatic send_msg(input bit exp_active);
        logic [9:0] w;
        logic       par;
        hold(1'b0, 3 * CPB);
        hold(1'b1, cv_hi);
        hold(1'b0, cv_lo);
        hold(1'b1, HALF);
        send_bit(1'b1);
        for (int k = 0; k < msg_n; k++) begin
            w = msg_words[k];
            for (int i = 9; i >= 0; i--) begin
                if (k == 0 && (9 - i) == reset_at) begin
                    reset = 1'b1;
                    repeat (3) @(negedge clk);
                    check_reset_values("midrst");
                    exp_q.delete();
                    exp_error = 0;
                    exp_code  = 0;
                    reset = 1'b0;
                    hold(1'b0, 5 * CPB);
                    return;
                end
                if (k == msg_sup && i == 4) begin
                    hold(~w[i], 3 * CPB);
                    hold(1'b0, 5 * CPB);
                    return;
                end
                send_bit(w[i]);
                if (k == 0 && i == 8) check("active_in_msg", active, int'(exp_active));
            end
            par = (^w) ^ msg_inv[k];
            send_bit(par);
            send_bit(k != msg_n - 1);
        end
        hold(1'b0, 5 * CPB);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        check("empty_after_drain", empty, 1);
    endtask

    task automatic finish_msg();
        if (reader_en) drain();
        check("active_idle", active, 0);
        check("error", error, exp_error);
        check("error_code", error_code, exp_code);
    endtask

    task automatic run_msg();
        bit act;
        model_msg(act);
        send_msg(act);
        finish_msg();
    endtask

    initial begin
        reset    = 1'b1;
        rx       = 1'b0;
        msg_sup  = -1;
        reset_at = -1;
        msg_inv  = '0;
        repeat (4) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        force_rd = 1'b1;
        repeat (3) @(negedge clk);
        force_rd = 1'b0;
        repeat (2) @(negedge clk);
        check("strobe_empty", empty, 1);
        check("strobe_data", data, 0);

        new_msg(1, 12, 12);
        msg_words[0] = 10'h3FF;
        run_msg();

        new_msg(3, 10, 14);
        msg_words[0] = 10'h001;
        msg_words[1] = 10'h2AA;
        msg_words[2] = 10'h155;
        run_msg();

        new_msg(2, 14, 10);
        msg_inv = 16'h0002;
        run_msg();

        reader_en = 1'b0;
        new_msg(9, 12, 12);
        run_msg();
        check("ovf_full", full, 1);
        check("ovf_empty", empty, 0);
        reader_en = 1'b1;
        drain();
        check("ovf_full_after_drain", full, 0);

        new_msg(3, 12, 12);
        msg_sup = 1;
        run_msg();

        for (int r = 0; r < 4; r++) begin
            new_msg(1, (r == 0) ? 9 : (r == 1) ? 15 : 12, (r == 2) ? 9 : (r == 3) ? 15 : 12);
            run_msg();
        end

        new_msg(2, 12, 12);
        reset_at = 5;
        send_msg(1'b1);
        finish_msg();

        new_msg(2, 11, 13);
        run_msg();

        for (int m = 0; m < 12; m++) begin
            int hi;
            int lo;
            hi = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 9 : 15)
                                             : int'($urandom_range(10, 14));
            lo = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 9 : 15)
                                             : int'($urandom_range(10, 14));
            new_msg(int'($urandom_range(1, 4)), hi, lo);
            for (int w = 0; w < msg_n; w++) msg_inv[w] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) msg_sup = int'($urandom_range(0, msg_n - 1));
            run_msg();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
